keypad_value_entry: RTL

- Front-panel input path, the counterpart of the multiplexed 7-segment output path.
- Scans a 4x4 matrix keypad by driving columns one at a time and sampling rows, then debounces the key state.
- Builds a decimal number of up to 4 digits, converts it BCD-to-binary and presents a 16-bit value.
- The BCD digits are echoed out for display.

---
 rtl/keypad_value_entry.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/keypad_value_entry.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : keypad_value_entry                                           |
// | Description : 4x4 matrix keypad scanner with sweep-level debounce and a    |
// |               4-digit decimal entry buffer that is converted BCD-to-binary |
// |               into a 16-bit value on the enter key.                        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module keypad_value_entry #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_SWEEPS = 4
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic [15:0] value,
    output logic        value_valid
);

    localparam logic [15:0] DWELL_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DEB_TARGET = 4'(DEBOUNCE_SWEEPS);

    logic [1:0]  col_q, col_d;
    logic [15:0] dwell_q, dwell_d;
    logic [15:0] snap_q, snap_d;
    logic [15:0] prev_q, prev_d;
    logic [15:0] stable_q, stable_d;
    logic [3:0]  deb_q, deb_d;
    logic [15:0] digits_q, digits_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] value_q, value_d;
    logic        valid_q, valid_d;

    logic        dwell_last;
    logic        sweep_done;
    logic        key_event;
    logic [3:0]  key_idx;
    logic [13:0] bcd_bin;

    // Digit carried by a key position; non-digit positions return 0 and are
    // filtered out by the action decode.
    function automatic logic [3:0] key_digit(input logic [3:0] idx);
        case (idx)
            4'd0:    key_digit = 4'd1;
            4'd1:    key_digit = 4'd2;
            4'd2:    key_digit = 4'd3;
            4'd4:    key_digit = 4'd4;
            4'd5:    key_digit = 4'd5;
            4'd6:    key_digit = 4'd6;
            4'd8:    key_digit = 4'd7;
            4'd9:    key_digit = 4'd8;
            4'd10:   key_digit = 4'd9;
            default: key_digit = 4'd0;
        endcase
    endfunction

    assign cols        = ~(4'b0001 << col_q);
    assign digits      = digits_q;
    assign digit_count = count_q;
    assign value       = value_q;
    assign value_valid = valid_q;

    // Column dwell timing and capture of the active column's rows into the snapshot
    always_comb begin
        dwell_last = (dwell_q == DWELL_LAST);
        sweep_done = dwell_last && (col_q == 2'd3);
        dwell_d    = dwell_last ? 16'd0 : dwell_q + 16'd1;
        col_d      = dwell_last ? col_q + 2'd1 : col_q;
        snap_d     = snap_q;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (dwell_last && (col_q == 2'(c))) begin
                    snap_d[r*4 + c] = ~rows[r];
                end
            end
        end
    end

    // Once per sweep: count identical sweeps, accept a new stable state, flag a key event
    always_comb begin
        prev_d    = prev_q;
        deb_d     = deb_q;
        stable_d  = stable_q;
        key_event = 1'b0;
        if (sweep_done) begin
            prev_d = snap_d;
            if (snap_d == prev_q) begin
                deb_d = (deb_q >= DEB_TARGET) ? DEB_TARGET : deb_q + 4'd1;
            end else begin
                deb_d = 4'd1;
            end
            if ((deb_d == DEB_TARGET) && (snap_d != stable_q)) begin
                stable_d  = snap_d;
                // Only a clean single press from the all-released state counts.
                key_event = (stable_q == 16'd0) && $onehot(snap_d);
            end
        end
    end

    // Position of the single pressed key in the new snapshot
    always_comb begin
        key_idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (snap_d[i]) begin
                key_idx = 4'(i);
            end
        end
    end

    assign bcd_bin = 14'(digits_q[15:12]) * 14'd1000 + 14'(digits_q[11:8]) * 14'd100
                   + 14'(digits_q[7:4]) * 14'd10 + 14'(digits_q[3:0]);

    // Entry buffer actions driven by the decoded key event
    always_comb begin
        digits_d = digits_q;
        count_d  = count_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        if (key_event) begin
            case (key_idx)
                4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd13: begin
                    if (count_q < 3'd4) begin
                        digits_d = {digits_q[11:0], key_digit(key_idx)};
                        count_d  = count_q + 3'd1;
                    end
                end
                4'd12: begin
                    if (count_q != 3'd0) begin
                        digits_d = {4'h0, digits_q[15:4]};
                        count_d  = count_q - 3'd1;
                    end
                end
                4'd11: begin
                    digits_d = 16'd0;
                    count_d  = 3'd0;
                end
                4'd14: begin
                    if (count_q != 3'd0) begin
                        value_d  = {2'b00, bcd_bin};
                        valid_d  = 1'b1;
                        digits_d = 16'd0;
                        count_d  = 3'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!nRst) begin
            col_q    <= 2'd0;
            dwell_q  <= 16'd0;
            snap_q   <= 16'd0;
            prev_q   <= 16'd0;
            stable_q <= 16'd0;
            deb_q    <= 4'd0;
            digits_q <= 16'd0;
            count_q  <= 3'd0;
            value_q  <= 16'd0;
            valid_q  <= 1'b0;
        end else begin
            col_q    <= col_d;
            dwell_q  <= dwell_d;
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            deb_q    <= deb_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
        end
    end

endmodule
`default_nettype wire
